// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, tile codes and write-scheduler states.
package board_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int NUM_CELLS = 1024;
  typedef enum logic [DATA_W-1:0] {EMPTY, WALL, PELLET, POWER, DOOR} tile_t;
  typedef enum logic {INIT, RUN} sched_state_t;
endpackage

// File: rtl/init_sweeper.sv
// init_sweeper: walks the board ROM once per start and tags which address rom_data belongs to.
module init_sweeper
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              sweepValid,
  output logic [ADDR_W-1:0] sweepAddr,
  output logic              sweepDone
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
  logic active;
  logic advance;
  assign advance = active && rom_addr != LAST_ADDR;
  // sweepValid/sweepAddr lag rom_addr by one cycle, lining up with the ROM read latency
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rom_addr   <= '0;
      active     <= 1'b1;
      sweepValid <= 1'b0;
      sweepAddr  <= '0;
      sweepDone  <= 1'b0;
    end else if (start) begin
      rom_addr   <= '0;
      active     <= 1'b1;
      sweepValid <= 1'b0;
      sweepDone  <= 1'b0;
    end else begin
      rom_addr   <= advance ? rom_addr + 1'b1 : rom_addr;
      active     <= advance;
      sweepValid <= active;
      sweepAddr  <= rom_addr;
      sweepDone  <= sweepValid && sweepAddr == LAST_ADDR;
    end
endmodule

// File: rtl/board_write_scheduler.sv
// board_write_scheduler: sole owner of the board-RAM write port; loads the maze from ROM,
// then arbitrates Pac-Man and ghost writes with starvation protection for the ghost.
module board_write_scheduler
  import board_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              pac_req,
  input  logic [ADDR_W-1:0] pac_addr,
  input  logic [DATA_W-1:0] pac_data,
  output logic              pac_gnt,
  input  logic              ghost_req,
  input  logic [ADDR_W-1:0] ghost_addr,
  input  logic [DATA_W-1:0] ghost_data,
  output logic              ghost_gnt,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] data2Write,
  output logic              writeEn,
  output logic              ready
);
  sched_state_t      state;
  logic              sweepValid;
  logic              sweepDone;
  logic [ADDR_W-1:0] sweepAddr;
  logic [3:0]        waitCnt;
  logic              starved;
  logic              live;

  init_sweeper sweeper (
    .clk        (clk),
    .reset      (reset),
    .start      (restart),
    .rom_addr   (rom_addr),
    .sweepValid (sweepValid),
    .sweepAddr  (sweepAddr),
    .sweepDone  (sweepDone)
  );

  assign live      = state == RUN && !restart;
  assign starved   = waitCnt == 4'(MAX_WAIT);
  assign pac_gnt   = live && pac_req && !(ghost_req && starved);
  assign ghost_gnt = live && ghost_req && (!pac_req || starved);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= INIT;
      ready      <= 1'b0;
      waitCnt    <= '0;
      writeEn    <= 1'b0;
      writeAddr  <= '0;
      data2Write <= '0;
    end else begin
      if (restart) begin
        state <= INIT;
        ready <= 1'b0;
      end else if (state == INIT && sweepDone) begin
        state <= RUN;
        ready <= 1'b1;
      end
      waitCnt <= (live && ghost_req && !ghost_gnt) ? (starved ? waitCnt : waitCnt + 1'b1) : '0;
      // a capture coinciding with restart belongs to the abandoned sweep, so it is dropped
      if (state == INIT) begin
        writeEn    <= sweepValid && !restart;
        writeAddr  <= sweepAddr;
        data2Write <= rom_data;
      end else begin
        writeEn    <= pac_gnt || ghost_gnt;
        writeAddr  <= pac_gnt ? pac_addr : ghost_gnt ? ghost_addr : writeAddr;
        data2Write <= pac_gnt ? pac_data : ghost_gnt ? ghost_data : data2Write;
      end
    end
endmodule

// File: tb/tb_board_write_scheduler.sv
// tb_board_write_scheduler: randomized scoreboard bench for the board write scheduler.
module tb_board_write_scheduler;
  import board_pkg::*;
  localparam int MW = 4;
  localparam int N = NUM_CELLS;

  logic clk = 0, reset = 0, restart = 0;
  logic [ADDR_W-1:0] rom_addr, writeAddr;
  logic [ADDR_W-1:0] pac_addr = '0, ghost_addr = '0;
  logic [DATA_W-1:0] rom_data = '0, pac_data = '0, ghost_data = '0, data2Write;
  logic pac_req = 0, ghost_req = 0, pac_gnt, ghost_gnt, writeEn, ready;

  int n_cmp = 0, n_err = 0;
  bit mrun = 0;
  int wc = 0;
  logic [ADDR_W+DATA_W-1:0] expq[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;

  board_write_scheduler #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pac_req    (pac_req),
    .pac_addr   (pac_addr),
    .pac_data   (pac_data),
    .pac_gnt    (pac_gnt),
    .ghost_req  (ghost_req),
    .ghost_addr (ghost_addr),
    .ghost_data (ghost_data),
    .ghost_gnt  (ghost_gnt),
    .writeAddr  (writeAddr),
    .data2Write (data2Write),
    .writeEn    (writeEn),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // board ROM: tile = address mod 16, one cycle read latency
  always @(posedge clk) rom_data <= rom_addr[3:0];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every visible write must be the oldest expected one
  always @(negedge clk)
    if (writeEn === 1'b1) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL write_unexpected: got addr %0d data %0d expected no write", writeAddr, data2Write);
      end else begin
        mon_e = expq.pop_front();
        check("write", 32'({writeAddr, data2Write}), 32'(mon_e));
      end
    end

  task automatic start_init();
    expq.delete();
    for (int i = 0; i < N; i++) expq.push_back({ADDR_W'(i), DATA_W'(i % 16)});
    mrun = 0;
    wc = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 0);
    check({tag, "_writeEn"}, 32'(writeEn), 0);
    check({tag, "_writeAddr"}, 32'(writeAddr), 0);
    check({tag, "_data2Write"}, 32'(data2Write), 0);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_pac_gnt"}, 32'(pac_gnt), 0);
    check({tag, "_ghost_gnt"}, 32'(ghost_gnt), 0);
  endtask

  // one RUN cycle: drive, predict grants from the arbitration rules, queue the resulting write
  task automatic step(input bit pr, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                      input bit gr, input logic [ADDR_W-1:0] ga, input logic [DATA_W-1:0] gd,
                      input bit rs, output bit ep, output bit eg, output bit ap, output bit ag);
    pac_req = pr; pac_addr = pa; pac_data = pd;
    ghost_req = gr; ghost_addr = ga; ghost_data = gd;
    restart = rs;
    ep = mrun && !rs && pr && !(gr && wc == MW);
    eg = mrun && !rs && gr && (!pr || wc == MW);
    @(negedge clk);
    ap = pac_gnt;
    ag = ghost_gnt;
    check("grant_ready", 32'({pac_gnt, ghost_gnt, ready}), 32'({ep, eg, mrun}));
    if (ep) expq.push_back({pa, pd});
    else if (eg) expq.push_back({ga, gd});
    wc = (mrun && !rs && gr && !eg) ? ((wc < MW) ? wc + 1 : MW) : 0;
    @(posedge clk); #1;
    restart = 0;
    if (rs) start_init();
  endtask

  task automatic idle();
    bit a, b, c, d;
    step(0, '0, '0, 0, '0, '0, 0, a, b, c, d);
  endtask

  // called at the start of c0; random requests must be ignored throughout the load
  task automatic run_init();
    int gv = 0, gaps = 0, early = 0;
    for (int k = 0; k < N + 2; k++) begin
      pac_req = (k < N + 1) ? 1'($urandom) : 1'b0;
      ghost_req = (k < N + 1) ? 1'($urandom) : 1'b0;
      pac_addr = ADDR_W'($urandom); pac_data = DATA_W'($urandom);
      ghost_addr = ADDR_W'($urandom); ghost_data = DATA_W'($urandom);
      @(negedge clk);
      if (pac_gnt !== 1'b0 || ghost_gnt !== 1'b0) gv++;
      if (ready !== 1'b0) early++;
      if (writeEn !== 1'(k >= 2 && k <= N + 1)) gaps++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("init_grants", 32'(gv), 0);
    check("init_early_ready", 32'(early), 0);
    check("init_write_gaps", 32'(gaps), 0);
    check("ready_at_c0_plus_N_plus_2", 32'(ready), 1);
    check("init_queue_drained", 32'(expq.size()), 0);
    mrun = 1;
    wc = 0;
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int n);
    bit pp = 0, gp = 0, ep, eg, ap, ag;
    logic [ADDR_W-1:0] pa = '0, ga = '0;
    logic [DATA_W-1:0] pd = '0, gd = '0;
    for (int i = 0; i < n; i++) begin
      if (!pp && $urandom_range(3) != 0) begin pp = 1; pa = ADDR_W'($urandom); pd = DATA_W'($urandom); end
      if (!gp && $urandom_range(1) != 0) begin gp = 1; ga = ADDR_W'($urandom); gd = DATA_W'($urandom); end
      step(pp, pa, pd, gp, ga, gd, 0, ep, eg, ap, ag);
      if (ep) pp = 0;
      if (eg) gp = 0;
    end
    idle();
  endtask

  initial begin
    bit ep, eg, ap, ag;
    int t;
    pac_req = 1; ghost_req = 1;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1;
    start_init();
    check("rom_addr_c0", 32'(rom_addr), 0);
    run_init();
    step(1, 10'd37, 4'd0, 0, '0, '0, 0, ep, eg, ap, ag);
    check("pac37_gnt", 32'({ap, ag}), 32'(2'b10));
    check("pac37_write", 32'({writeEn, writeAddr, data2Write}), 32'({1'b1, 10'd37, 4'd0}));
    idle();
    for (int i = 0; i < 10; i++) begin
      step(1, ADDR_W'(100 + i), DATA_W'(i), 1, ADDR_W'(200 + i), DATA_W'(i + 1), 0, ep, eg, ap, ag);
      check("starve_pattern", 32'({ap, ag}), (i % 5 == 4) ? 32'(2'b01) : 32'(2'b10));
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step(0, '0, '0, 1, 10'd500, 4'd2, 0, ep, eg, ap, ag);
      check("ghost500_gnt", 32'(ag), 1);
      check("ghost500_write", 32'({writeEn, writeAddr, data2Write}), 32'({1'b1, 10'd500, 4'd2}));
    end
    idle();
    rand_run(600);
    step(1, 10'd5, 4'd1, 0, '0, '0, 1, ep, eg, ap, ag);
    check("restart_blocks_gnt", 32'(ap), 0);
    check("restart_ready_low", 32'(ready), 0);
    run_init();
    rand_run(50);
    step(0, '0, '0, 0, '0, '0, 1, ep, eg, ap, ag);
    t = 0;
    while (rom_addr !== 10'd300 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("reach_rom_addr_300", 32'(t), 300);
    #2;
    pac_req = 1; ghost_req = 1;
    reset = 0;
    #1;
    check_reset_vals("async_reset");
    expq.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    start_init();
    check("rom_addr_after_reset", 32'(rom_addr), 0);
    run_init();
    rand_run(100);
    idle();
    check("final_queue_empty", 32'(expq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
